// File: rtl/phase_addr_gen_if.sv
// Control/config inputs and phase/address outputs of the phase/address generator.
// master drives the controls (datapath controller); slave is the generator itself.
interface phase_addr_gen_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic               en;
  logic               dir;
  logic               oneshot;
  logic               start;
  logic [WIDTH-1:0]   step;
  logic               cfg_we;
  logic [CHW-1:0]     cfg_ch;
  logic [WIDTH-1:0]   cfg_offset;
  logic [WIDTH-1:0]   phase;
  logic [NCH*WIDTH-1:0] addr;
  logic               wrap;
  logic               done;

  modport master (
    output en, dir, oneshot, start, step, cfg_we, cfg_ch, cfg_offset,
    input  phase, addr, wrap, done
  );

  modport slave (
    input  en, dir, oneshot, start, step, cfg_we, cfg_ch, cfg_offset,
    output phase, addr, wrap, done
  );
endinterface

// File: rtl/phase_addr_gen.sv
// Phase accumulator with per-channel offset addresses; phase/wrap/done 1 cycle, addr 2 cycles.
// No backpressure: the accumulator advances every enabled cycle until a one-shot wrap halts it.
module phase_addr_gen #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic clk,
  input  logic rst,
  phase_addr_gen_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {ST_RUN, ST_DONE} state_t;

  state_t                     state;
  logic [WIDTH-1:0]           phase_q;
  logic                       wrap_q;
  logic [NCH-1:0][WIDTH-1:0]  offset_q;
  logic [NCH-1:0][WIDTH-1:0]  addr_q;

  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH-1:0] phase_nxt;
  logic             wrap_nxt;
  logic             cfg_hit;

  // The extra MSB of the widened sum/difference is the carry or borrow.
  always_comb begin
    up_sum    = {1'b0, phase_q} + {1'b0, bus.step};
    dn_diff   = {1'b0, phase_q} - {1'b0, bus.step};
    phase_nxt = bus.dir ? dn_diff[WIDTH-1:0] : up_sum[WIDTH-1:0];
    wrap_nxt  = bus.dir ? dn_diff[WIDTH] : up_sum[WIDTH];
    cfg_hit   = bus.cfg_we && (int'(bus.cfg_ch) < NCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      phase_q  <= '0;
      wrap_q   <= 1'b0;
      offset_q <= '0;
      addr_q   <= '0;
    end else begin
      if (bus.start) begin
        state   <= ST_RUN;
        phase_q <= '0;
        wrap_q  <= 1'b0;
      end else if (bus.en && state == ST_RUN) begin
        phase_q <= phase_nxt;
        wrap_q  <= wrap_nxt;
        if (bus.oneshot && wrap_nxt)
          state <= ST_DONE;
      end else begin
        wrap_q <= 1'b0;
      end

      if (cfg_hit)
        offset_q[bus.cfg_ch] <= bus.cfg_offset;

      // Addresses use the registered phase/offsets, so they trail phase by one cycle.
      for (int k = 0; k < NCH; k++)
        addr_q[k] <= phase_q - offset_q[k];
    end
  end

  assign bus.phase = phase_q;
  assign bus.wrap  = wrap_q;
  assign bus.done  = (state == ST_DONE);
  assign bus.addr  = addr_q;

endmodule
